data_upload: RTL

DATA_UPLOAD -- requirements
Module: data_upload

---
 rtl/data_upload_pkg.sv | 19 +
 rtl/data_upload_sync.sv | 39 +++
 rtl/data_upload.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/data_upload_pkg.sv
// data_upload_pkg: SPI command codes and FSM state encoding shared by the
// data_upload engine and its bench.
package data_upload_pkg;

    localparam logic [7:0] CMD_ADDR   = 8'h53;
    localparam logic [7:0] CMD_STREAM = 8'h54;
    localparam logic [7:0] CMD_CHK    = 8'h55;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        STREAM,
        CHK,
        IGNORE
    } state_t;

endpackage

// File: rtl/data_upload_sync.sv
// spi_sync_edge: brings the SPI pins into the clk domain with two flops each
// and flags SCK rising/falling edges as one-clk pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic spi_sck,
    input  logic spi_ss,
    input  logic spi_sdi,
    output logic ss_s,
    output logic sdi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic [1:0] sck_m;
    logic [1:0] ss_m;
    logic [1:0] sdi_m;
    logic       sck_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_m <= 2'b00;
            ss_m  <= 2'b11;
            sdi_m <= 2'b00;
            sck_q <= 1'b0;
        end else begin
            sck_m <= {sck_m[0], spi_sck};
            ss_m  <= {ss_m[0], spi_ss};
            sdi_m <= {sdi_m[0], spi_sdi};
            sck_q <= sck_m[1];
        end
    end

    assign ss_s     = ss_m[1];
    assign sdi_s    = sdi_m[1];
    assign sck_rise = sck_m[1] & ~sck_q;
    assign sck_fall = ~sck_m[1] & sck_q;

endmodule

// File: rtl/data_upload.sv
// data_upload: SPI slave that streams memory bytes to the io controller.
// Build with DATA_UPLOAD_CHECKSUM_EN defined to get the XOR checksum on 0x55.
//
// state  | meaning
// IDLE   | deselected, waiting for spi_ss low
// CMD    | receiving a command byte
// ADDR   | receiving 3 address bytes, MSB first
// STREAM | transmitting sequential memory bytes until deselect
// CHK    | transmitting the checksum byte
// IGNORE | unknown command, sdo held high until deselect
module data_upload
    import data_upload_pkg::*;
#(
    parameter int                ADDR_W = 25,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              uploading,
    output logic              underrun
);

    state_t      state, state_nxt;
    logic        ss_s, sdi_s, sck_rise, sck_fall;
    logic [2:0]  bit_cnt;
    logic [1:0]  addr_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  tx_sr;
    logic [7:0]  buf_data;
    logic        buf_vld, discard, fetch_pend;
    logic [7:0]  rx_byte, stream_byte, chk_byte;
    logic [23:0] addr_ld;
    logic        byte_done, boundary, in_stream, stream_ld;
    logic        accept, fwd, take, start_stream, addr_load, want_fetch;

    spi_sync_edge u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_sck  (spi_sck),
        .spi_ss   (spi_ss),
        .spi_sdi  (spi_sdi),
        .ss_s     (ss_s),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    assign rx_byte      = {rx_sr, sdi_s};
    assign byte_done    = sck_rise & ~ss_s & (bit_cnt == 3'd7);
    assign boundary     = sck_fall & ~ss_s & (bit_cnt == 3'd0);
    assign in_stream    = (state == STREAM);
    assign stream_ld    = in_stream & boundary;
    assign accept       = mem_ack & mem_rd & in_stream & ~discard;
    assign fwd          = accept & stream_ld & ~buf_vld;
    assign take         = stream_ld & (buf_vld | fwd);
    assign stream_byte  = buf_vld ? buf_data : (fwd ? mem_data : FILL_BYTE);
    assign start_stream = (state == CMD) & byte_done & (rx_byte == CMD_STREAM);
    assign addr_load    = (state == ADDR) & byte_done;
    assign addr_ld      = {16'(mem_addr), rx_byte};
    assign want_fetch   = fetch_pend | start_stream | take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ss_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            CMD_ADDR:   state_nxt = ADDR;
                            CMD_STREAM: state_nxt = STREAM;
                            CMD_CHK:    state_nxt = CHK;
                            default:    state_nxt = IGNORE;
                        endcase
                    end
                end
                ADDR:    if (byte_done && addr_cnt == 2'd2) state_nxt = CMD;
                CHK:     if (byte_done) state_nxt = CMD;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            addr_cnt   <= '0;
            rx_sr      <= '0;
            tx_sr      <= FILL_BYTE;
            buf_data   <= '0;
            buf_vld    <= 1'b0;
            discard    <= 1'b0;
            fetch_pend <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= BASE;
            underrun   <= 1'b0;
        end else begin
            if (ss_s) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte[6:0];
            end

            if (state != ADDR)  addr_cnt <= '0;
            else if (byte_done) addr_cnt <= addr_cnt + 2'd1;

            // The first fall of each byte loads the next byte; others shift.
            if (sck_fall && !ss_s) begin
                if (bit_cnt == 3'd0)
                    tx_sr <= in_stream ? stream_byte :
                             (state == CHK) ? chk_byte : FILL_BYTE;
                else
                    tx_sr <= {tx_sr[6:0], 1'b1};
            end

            if (ss_s) begin
                buf_vld <= 1'b0;
            end else if (take) begin
                buf_vld <= 1'b0;
            end else if (accept) begin
                buf_vld  <= 1'b1;
                buf_data <= mem_data;
            end

            if (stream_ld && !buf_vld && !fwd) underrun <= 1'b1;

            // A read left outstanding by a deselect completes, but its data is dropped.
            if (mem_ack)            discard <= 1'b0;
            else if (ss_s && mem_rd) discard <= 1'b1;

            fetch_pend <= want_fetch & ~ss_s & mem_rd;
            if (mem_rd && mem_ack) begin
                mem_rd   <= 1'b0;
                mem_addr <= mem_addr + ADDR_W'(1);
            end else if (want_fetch && !ss_s && !mem_rd) begin
                mem_rd <= 1'b1;
            end else if (addr_load) begin
                mem_addr <= ADDR_W'(addr_ld);
            end
        end
    end

`ifdef DATA_UPLOAD_CHECKSUM_EN
    logic [7:0] csum, cur_byte;

    // Folding in at byte completion keeps a byte cut short by deselect out of the sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum     <= '0;
            cur_byte <= '0;
        end else begin
            if (stream_ld) cur_byte <= stream_byte;
            if (start_stream)               csum <= '0;
            else if (in_stream && byte_done) csum <= csum ^ cur_byte;
        end
    end

    assign chk_byte = csum;
`else
    assign chk_byte = 8'h00;
`endif

    assign spi_sdo    = (in_stream || state == CHK) ? tx_sr[7] : 1'b1;
    assign spi_sdo_oe = ~ss_s;
    assign uploading  = in_stream;

endmodule
